button_debounce_multi: RTL

//  Parametrised multi-channel push-button conditioner for the front panel.
//  Per channel: 2-flop synchroniser, counter-based debounce, registered level,

---
 rtl/button_debounce_multi_if.sv | 23 ++
 rtl/button_debounce_multi.sv | 113 +++++++++++
 2 files changed

// File: rtl/button_debounce_multi_if.sv
// button_debounce_multi_if: raw button pins and conditioned outputs of button_debounce_multi
//  i_button         raw asynchronous pins (driven by master)
//  o_pressed        debounced level, 1 = pressed
//  o_press_pulse    1-cycle pulse on debounced press
//  o_release_pulse  1-cycle pulse on debounced release
//  o_hold           long-press level
interface button_debounce_multi_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] i_button;
  logic [NUM_BTN-1:0] o_pressed;
  logic [NUM_BTN-1:0] o_press_pulse;
  logic [NUM_BTN-1:0] o_release_pulse;
  logic [NUM_BTN-1:0] o_hold;
  modport master (
    output i_button,
    input  o_pressed, o_press_pulse, o_release_pulse, o_hold
  );
  modport slave (
    input  i_button,
    output o_pressed, o_press_pulse, o_release_pulse, o_hold
  );
endinterface

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: per-channel synchroniser, counter debounce, press/release pulses and hold flag
//  i_clk    system clock, rising edge
//  i_rst_n  asynchronous active-low reset, synchronous release expected
//  bus      slave side: i_button in; o_pressed, o_press_pulse, o_release_pulse, o_hold out
module button_debounce_multi #(
  parameter int NUM_BTN      = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  button_debounce_multi_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYC - 1);
  localparam bit HOLD_EN = (HOLD_CYC != 0);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [HW-1:0] hcnt, hcnt_nx;
    logic          s1, ps;
    logic          pressed, pressed_nx;
    logic          hold, hold_nx;
    logic          pp, pp_nx;
    logic          rp, rp_nx;
    // Synchroniser works on the polarity-normalised level so reset value 0 means released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1      <= 1'b0;
        ps      <= 1'b0;
        state   <= RELEASED;
        cnt     <= '0;
        hcnt    <= '0;
        pressed <= 1'b0;
        hold    <= 1'b0;
        pp      <= 1'b0;
        rp      <= 1'b0;
      end else begin
        s1      <= bus.i_button[i] ^ ACTIVE_LOW;
        ps      <= s1;
        state   <= state_nx;
        cnt     <= cnt_nx;
        hcnt    <= hcnt_nx;
        pressed <= pressed_nx;
        hold    <= hold_nx;
        pp      <= pp_nx;
        rp      <= rp_nx;
      end
    end
    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      hcnt_nx    = hcnt;
      pressed_nx = pressed;
      hold_nx    = hold;
      pp_nx      = 1'b0;
      rp_nx      = 1'b0;
      // Hold timing runs through release glitches, so count in both pressed-side states.
      if (state == PRESSED || state == RELEASE_WAIT) begin
        hcnt_nx = (hcnt == HOLD_MAX) ? hcnt : hcnt + 1'b1;
        hold_nx = hold | (HOLD_EN && hcnt == HOLD_PRE);
      end
      case (state)
        RELEASED:
          if (ps) begin
            state_nx = PRESS_WAIT;
            cnt_nx   = CW'(1);
          end
        PRESS_WAIT:
          if (!ps) begin
            state_nx = RELEASED;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx   = PRESSED;
            cnt_nx     = '0;
            hcnt_nx    = '0;
            pressed_nx = 1'b1;
            pp_nx      = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        PRESSED:
          if (!ps) begin
            state_nx = RELEASE_WAIT;
            cnt_nx   = CW'(1);
          end
        RELEASE_WAIT:
          if (ps) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx   = RELEASED;
            cnt_nx     = '0;
            pressed_nx = 1'b0;
            hold_nx    = 1'b0;
            rp_nx      = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        default: state_nx = RELEASED;
      endcase
    end
    assign bus.o_pressed[i]       = pressed;
    assign bus.o_press_pulse[i]   = pp;
    assign bus.o_release_pulse[i] = rp;
    assign bus.o_hold[i]          = hold;
  end
endmodule
